// File: rtl/db_to_linear_if.sv
// Valid/ready bundle for the dB-to-linear converter.
// Input side carries a Q8.8 dB value, output side linear power.
interface db_to_linear_if #(
  parameter int IN_WIDTH = 16,
  parameter int DB_INT   = 8,
  parameter int DB_FRAC  = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic [DB_INT+DB_FRAC-1:0] db_in;
  logic                      out_valid;
  logic                      out_ready;
  logic [2*IN_WIDTH-1:0]     lin_out;
  logic                      sat;

  modport master (
    output in_valid, db_in, out_ready,
    input  in_ready, out_valid, lin_out, sat
  );

  modport slave (
    input  in_valid, db_in, out_ready,
    output in_ready, out_valid, lin_out, sat
  );
endinterface

// File: rtl/db_to_linear.sv
// Converts unsigned Q8.8 dB to linear power, P = 10^(dB/10),
// via 2^(dB*log2(10)/10) with an interpolated 2^f mantissa table.
module db_to_linear #(
  parameter int IN_WIDTH = 16,
  parameter int DB_INT   = 8,
  parameter int DB_FRAC  = 8,
  parameter int LUT_BITS = 5
) (
  input logic clk,
  input logic rst,
  db_to_linear_if.slave bus
);

  localparam int DB_W   = DB_INT + DB_FRAC;
  localparam int OUT_W  = 2 * IN_WIDTH;
  localparam int FRAC_W = DB_FRAC + 16;
  localparam int SPARE  = FRAC_W - LUT_BITS - 8;
  localparam int WIDE   = OUT_W + 17;
  localparam int LUT_N  = (1 << LUT_BITS) + 1;

  localparam logic [15:0] K = 16'd21771;
  localparam logic [DB_INT-1:0] N_MAX = DB_INT'(OUT_W);
  localparam logic [WIDE-1:0] HALF =
    {{(WIDE-15){1'b0}}, 15'h4000};

  // round(2^(k/32) * 32768), Q1.15
  localparam logic [16:0] EXP2_TAB [LUT_N] = '{
    17'd32768, 17'd33486, 17'd34219, 17'd34968,
    17'd35734, 17'd36516, 17'd37316, 17'd38133,
    17'd38968, 17'd39821, 17'd40693, 17'd41584,
    17'd42495, 17'd43425, 17'd44376, 17'd45348,
    17'd46341, 17'd47356, 17'd48393, 17'd49452,
    17'd50535, 17'd51642, 17'd52773, 17'd53928,
    17'd55109, 17'd56316, 17'd57549, 17'd58809,
    17'd60097, 17'd61413, 17'd62757, 17'd64132,
    17'd65536
  };

  typedef enum logic [2:0] {
    IDLE, MUL, LUT, SHIFT, HOLD
  } state_t;

  state_t state;

  logic [DB_W-1:0]     db_q;
  logic [DB_INT-1:0]   n_q;
  logic [LUT_BITS-1:0] idx_q;
  logic [7:0]          frac_q;
  logic [16:0]         mant_q;

  logic [DB_W+15:0]    l_c;
  logic [DB_INT-1:0]   n_c;
  logic [LUT_BITS-1:0] idx_c;
  logic [7:0]          frac_c;
  logic [SPARE-1:0]    unused_f;

  logic [16:0] m0;
  logic [16:0] m1;
  logic [24:0] prod;
  logic [16:0] step;
  logic [7:0]  unused_p;
  logic [16:0] mant_c;

  logic [WIDE-1:0]  wide;
  logic [OUT_W+1:0] res;
  logic [14:0]      unused_r;
  logic             ovf;

  always_comb begin
    l_c = {16'b0, db_q} * {{DB_W{1'b0}}, K};
    {n_c, idx_c, frac_c, unused_f} = l_c;

    m0 = EXP2_TAB[{1'b0, idx_q}];
    m1 = EXP2_TAB[{1'b0, idx_q} + (LUT_BITS+1)'(1)];
    prod = {8'b0, m1 - m0} * {17'b0, frac_q};
    {step, unused_p} = prod;
    mant_c = m0 + step;

    wide = ({{(WIDE-17){1'b0}}, mant_q} << n_q) + HALF;
    {res, unused_r} = wide;
    ovf = |res[OUT_W+1:OUT_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.lin_out   <= '0;
      bus.sat       <= 1'b0;
      db_q          <= '0;
      n_q           <= '0;
      idx_q         <= '0;
      frac_q        <= '0;
      mant_q        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            db_q         <= bus.db_in;
            bus.in_ready <= 1'b0;
            state        <= MUL;
          end
        end
        MUL: begin
          n_q    <= n_c;
          idx_q  <= idx_c;
          frac_q <= frac_c;
          state  <= LUT;
        end
        LUT: begin
          mant_q <= mant_c;
          state  <= SHIFT;
        end
        SHIFT: begin
          if (n_q >= N_MAX || ovf) begin
            bus.lin_out <= '1;
            bus.sat     <= 1'b1;
          end else begin
            bus.lin_out <= res[OUT_W-1:0];
            bus.sat     <= 1'b0;
          end
          bus.out_valid <= 1'b1;
          state         <= HOLD;
        end
        HOLD: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_db_to_linear.sv
// Bench for db_to_linear: directed points, backpressure, reset
// and a random sweep against a real-valued 10^(dB/10) model.
module tb_db_to_linear;

  localparam int IN_WIDTH = 16;
  localparam int DB_INT   = 8;
  localparam int DB_FRAC  = 8;
  localparam int LUT_BITS = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  db_to_linear_if #(
    .IN_WIDTH(IN_WIDTH), .DB_INT(DB_INT), .DB_FRAC(DB_FRAC)
  ) bus ();

  db_to_linear #(
    .IN_WIDTH(IN_WIDTH), .DB_INT(DB_INT),
    .DB_FRAC(DB_FRAC), .LUT_BITS(LUT_BITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic real ideal_of(input logic [15:0] db);
    return $pow(10.0, real'(db) / 2560.0);
  endfunction

  // While a result is pending, it must stay put; never ready on both sides.
  logic        p_valid = 1'b0;
  logic        p_ready = 1'b0;
  logic        p_rst   = 1'b1;
  logic [31:0] p_lin   = '0;
  logic        p_sat   = 1'b0;

  always @(negedge clk) begin
    if (!p_rst) begin
      if (p_valid && !p_ready) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.lin_out !== p_lin ||
            bus.sat !== p_sat) begin
          errors++;
          $display("FAIL hold_stable: valid=%b lin=%h sat=%b, expected valid=1 lin=%h sat=%b",
                   bus.out_valid, bus.lin_out, bus.sat, p_lin, p_sat);
        end
      end
      checks++;
      if (bus.out_valid === 1'b1 && bus.in_ready === 1'b1) begin
        errors++;
        $display("FAIL ready_and_valid: in_ready=%b out_valid=%b, expected not both 1",
                 bus.in_ready, bus.out_valid);
      end
    end
    p_valid <= bus.out_valid;
    p_ready <= bus.out_ready;
    p_lin   <= bus.lin_out;
    p_sat   <= bus.sat;
    p_rst   <= rst;
  end

  task automatic convert(input logic [15:0] db, input int hold,
                         output logic [31:0] lin, output logic s,
                         output int lat);
    int w;
    lin = '0;
    s   = 1'b0;
    lat = -1;
    w   = 0;
    while (bus.in_ready !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout db=%h: in_ready=%b, expected 1",
               db, bus.in_ready);
      return;
    end
    bus.db_in    = db;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.db_in    = 16'($urandom);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    if (bus.out_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL result_timeout db=%h: out_valid=%b, expected 1",
               db, bus.out_valid);
      lat = -1;
      return;
    end
    lin = bus.lin_out;
    s   = bus.sat;
    repeat (hold) tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.in_valid  = 1'b1;
    bus.db_in     = 16'h0A00;
    bus.out_ready = 1'b0;
    repeat (2) tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    checks++;
    if (bus.lin_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_lin_out: got %h expected 0", bus.lin_out);
    end
    checks++;
    if (bus.sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_sat: got %b expected 0", bus.sat);
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_no_capture: valid=%b ready=%b expected 0/1",
                 bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_directed;
    logic [15:0] db_t [7] = '{16'h0000, 16'h0A00, 16'h1E00, 16'h0303,
                              16'h6000, 16'h6400, 16'hFFFF};
    longint lo_t [7] = '{1, 10, 999, 2, 64'd3977090634,
                         64'hFFFFFFFF, 64'hFFFFFFFF};
    longint hi_t [7] = '{1, 10, 1001, 2, 64'd3985052777,
                         64'hFFFFFFFF, 64'hFFFFFFFF};
    logic sat_t [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] lin;
    logic s;
    int lat;
    longint v;
    for (int i = 0; i < 7; i++) begin
      convert(db_t[i], i % 3, lin, s, lat);
      v = longint'(lin);
      checks++;
      if (lat != 4) begin
        errors++;
        $display("FAIL directed_latency db=%h: got %0d expected 4",
                 db_t[i], lat);
      end
      checks++;
      if (v < lo_t[i] || v > hi_t[i]) begin
        errors++;
        $display("FAIL directed_value db=%h: got %0d expected %0d..%0d",
                 db_t[i], lin, lo_t[i], hi_t[i]);
      end
      checks++;
      if (s !== sat_t[i]) begin
        errors++;
        $display("FAIL directed_sat db=%h: got %b expected %b",
                 db_t[i], s, sat_t[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] lin0;
    logic sat0;
    int lat;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_idle_ready: got %b expected 1", bus.in_ready);
    end
    bus.db_in    = 16'h1400;
    bus.in_valid = 1'b1;
    tick();
    bus.db_in = 16'h0A00;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL bp_latency: got %0d expected 4", lat);
    end
    lin0 = bus.lin_out;
    sat0 = bus.sat;
    checks++;
    if (lin0 !== 32'd100 || sat0 !== 1'b0) begin
      errors++;
      $display("FAIL bp_value: got %0d sat=%b expected 100 sat=0",
               lin0, sat0);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.lin_out !== lin0 || bus.sat !== sat0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: valid=%b ready=%b lin=%0d sat=%b expected 1/0/%0d/%b",
                 i, bus.out_valid, bus.in_ready, bus.lin_out, bus.sat,
                 lin0, sat0);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_handshake_ready: got %b expected 0", bus.in_ready);
    end
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_after_hs: ready=%b valid=%b expected 1/0",
               bus.in_ready, bus.out_valid);
    end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_second_accept: in_ready=%b expected 0",
               bus.in_ready);
    end
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != 4 || bus.lin_out !== 32'd10) begin
      errors++;
      $display("FAIL bp_second: lat=%0d lin=%0d expected 4/10",
               lat, bus.lin_out);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [31:0] lin;
    logic s;
    int lat;
    bus.db_in    = 16'h6000;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_busy: in_ready=%b expected 0", bus.in_ready);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.lin_out !== 32'h0 || bus.sat !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: ready=%b valid=%b lin=%h sat=%b expected 1/0/0/0",
               bus.in_ready, bus.out_valid, bus.lin_out, bus.sat);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_stale cycle %0d: out_valid=%b expected 0",
                 i, bus.out_valid);
      end
    end
    convert(16'h0A00, 1, lin, s, lat);
    checks++;
    if (lin !== 32'd10 || s !== 1'b0 || lat != 4) begin
      errors++;
      $display("FAIL mid_recover: lin=%0d sat=%b lat=%0d expected 10/0/4",
               lin, s, lat);
    end
  endtask

  task automatic test_random;
    logic [15:0] db;
    logic [31:0] lin;
    logic s;
    int lat;
    real ideal;
    real tol;
    real diff;
    for (int i = 0; i < 1000; i++) begin
      if (i == 0) db = 16'h0000;
      else if (i == 1) db = 16'h6000;
      else db = 16'($urandom_range(0, 24576));
      convert(db, $urandom_range(0, 2), lin, s, lat);
      ideal = ideal_of(db);
      tol = ideal * 0.001;
      if (tol < 1.0) tol = 1.0;
      diff = real'(longint'(lin)) - ideal;
      if (diff < 0.0) diff = -diff;
      checks++;
      if (lat != 4) begin
        errors++;
        $display("FAIL rand_latency db=%h: got %0d expected 4", db, lat);
      end
      checks++;
      if (s !== 1'b0 || diff > tol) begin
        errors++;
        $display("FAIL rand_value db=%h: got %0d sat=%b expected %f +/- %f sat=0",
                 db, lin, s, ideal, tol);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.db_in     = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
